branch_predict_gshare_spec: RTL and testbench
=============================================

BRANCH_PREDICT_GSHARE_SPEC -- requirements
Module: branch_predict_gshare_spec

Interface
REQ-001 Parameter PHT_DEPTH, default 8: PHT index width; the PHT holds 2^PHT_DEPTH entries.
REQ-002 Parameter GHR_LEN, default 8: global history length, legal range 2..PHT_DEPTH.
REQ-003 Parameter CTR_W, default 2: saturating counter width per PHT entry, legal range 2..4.
REQ-004 Parameter CNT_W, default 32: width of each performance counter.
REQ-005 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-006 Port rst, input, 1: asynchronous active-low reset; rst=0 resets all state immediately.
REQ-007 Ports pcF, input, 32: fetch PC. pcM is not a port; the index travels with the instruction.
REQ-008 Ports stallD, flushD, flushE, flushM, input, 1 each: pipeline hold/kill controls for D, E, M.
REQ-009 Ports branchD, branchM, input, 1 each: a conditional branch is in D / in M.
REQ-010 Port actual_takeM, input, 1: resolved branch direction in M.
REQ-011 Port pred_takeD, output, 1: predicted taken; equals branchD & predD.
REQ-012 Port mispredictM, output, 1: equals branchM & (predM != actual_takeM).
REQ-013 Port PHT_index, output, PHT_DEPTH: fetch-stage index, for debug.
REQ-014 Port ghr_spec, output, GHR_LEN: speculative history, for debug.
REQ-015 Ports branch_cnt and mispred_cnt, output, CNT_W each: performance counters.

Function
REQ-016 Fetch index = pcF[PHT_DEPTH+1:2] XOR the zero-extended ghr_spec.
REQ-017 predF = MSB of PHT[PHT_index]; the read is combinational.
REQ-018 predF and PHT_index pass F->D->E->M in stage registers.
REQ-019 Each stage register clears when its flush input is set; flush has priority over enable.
REQ-020 The D register holds while stallD=1; the E and M registers always advance.
REQ-021 PHT update at M uses the carried index idxM, not a recomputed one.
REQ-022 On branchM=1, PHT[idxM] increments on actual_takeM=1, saturating at 2^CTR_W-1.
REQ-023 On branchM=1, PHT[idxM] decrements on actual_takeM=0, saturating at 0.
REQ-024 A same-cycle F read of the entry being updated returns the pre-update value; there is no bypass.
REQ-025 ghr_arch shifts in actual_takeM whenever branchM=1.
REQ-026 ghr_spec shifts in predD when branchD & ~stallD & ~flushE, i.e. a branch advances D->E.
REQ-027 On mispredictM=1, ghr_spec <= {ghr_arch[GHR_LEN-2:0], actual_takeM}.
REQ-028 Recovery (REQ-027) has priority over a same-cycle speculative shift (REQ-026).
REQ-029 branch_cnt increments on each branchM=1, saturating at all-ones with no wrap.
REQ-030 mispred_cnt increments on each mispredictM=1, saturating at all-ones with no wrap.
REQ-031 Latency: a resolution at M edge N is visible to a fetch in cycle N+1.

Reset
REQ-032 While rst=0: every PHT entry = 2^(CTR_W-1) (weakly taken).
REQ-033 While rst=0: ghr_spec = ghr_arch = 0.
REQ-034 While rst=0: all stage registers = 0, so pred_takeD=0 and mispredictM=0.
REQ-035 While rst=0: both counters = 0.
REQ-036 A reset asserted mid-operation discards all in-flight predictions; there is no partial update.

Structure
REQ-037 The shared defines file holds the counter-state encodings and the CTR_INIT expression.
REQ-038 One sub-module, bp_stage_reg: parametrised-width register with async active-low reset, synchronous clear and enable, instantiated per stage.

Verification (PHT_DEPTH=8, GHR_LEN=8, CTR_W=2)
REQ-039 Reset, then pcF=0x00000010 fetched and branchD=1 in D -> pred_takeD=1, PHT_index=0x04, both counters 0.
REQ-040 Branch at pc 0x40 resolves not-taken twice; ghr stays 0 and idx is 0x10 -> counter goes 2,1,0 and the third fetch gives pred_takeD=0.
REQ-041 Two predicted-taken branches advance D->E (ghr_spec=0x03, ghr_arch=0x00), then branchM with predM=1, actual_takeM=0 -> mispredictM=1 and next cycle ghr_spec=0x00, ghr_arch=0x00.
REQ-042 mispredictM=1 and a branch advancing D->E in the same cycle -> ghr_spec equals the recovered value and ignores predD.
REQ-043 stallD=1 for 3 cycles with branchD=1 -> predD held, ghr_spec shifts exactly once after release; flushE on release -> no shift.
REQ-044 10 resolutions with 3 mispredicts -> branch_cnt=10, mispred_cnt=3; with CNT_W=4 and 20 resolutions -> branch_cnt=15.

Source files
------------

// File: rtl/branch_predict_gshare_spec_pkg.sv
// Shared definitions for the gshare predictor: counter-state encodings and
// helpers that derive the reset and saturation values for a given counter width.
package branch_predict_gshare_spec_pkg;

    localparam int CTR_W_MAX = 4;

    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctr2_state_e;

    // Weakly-taken reset value: only the MSB set.
    function automatic logic [CTR_W_MAX-1:0] ctr_init(input int ctr_w);
        ctr_init = 4'b0001 << (ctr_w - 1);
    endfunction

    function automatic logic [CTR_W_MAX-1:0] ctr_max(input int ctr_w);
        ctr_max = 4'b1111 >> (CTR_W_MAX - ctr_w);
    endfunction

endpackage

// File: rtl/branch_predict_gshare_spec_if.sv
// Pipeline-side signal bundle of the gshare predictor; the pipeline is the
// master, the predictor the slave.
interface branch_predict_gshare_spec_if #(
    parameter int PHT_DEPTH = 8,
    parameter int GHR_LEN   = 8,
    parameter int CNT_W     = 32
);
    logic [31:0]          pcF;
    logic                 stallD;
    logic                 flushD;
    logic                 flushE;
    logic                 flushM;
    logic                 branchD;
    logic                 branchM;
    logic                 actual_takeM;
    logic                 pred_takeD;
    logic                 mispredictM;
    logic [PHT_DEPTH-1:0] PHT_index;
    logic [GHR_LEN-1:0]   ghr_spec;
    logic [CNT_W-1:0]     branch_cnt;
    logic [CNT_W-1:0]     mispred_cnt;

    modport master (
        output pcF, stallD, flushD, flushE, flushM, branchD, branchM, actual_takeM,
        input  pred_takeD, mispredictM, PHT_index, ghr_spec, branch_cnt, mispred_cnt
    );

    modport slave (
        input  pcF, stallD, flushD, flushE, flushM, branchD, branchM, actual_takeM,
        output pred_takeD, mispredictM, PHT_index, ghr_spec, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_gshare_spec_bp_stage_reg.sv
// Pipeline stage register: async active-low reset, synchronous clear that
// wins over the enable.
module bp_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Stage contents: reset, flush, hold or load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= {W{1'b0}};
        end else if (clr_i) begin
            q_o <= {W{1'b0}};
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/branch_predict_gshare_spec.sv
// Gshare branch predictor: PHT of saturating counters indexed by PC xor
// speculative history, with the fetch index carried down to M for the update.
module branch_predict_gshare_spec
    import branch_predict_gshare_spec_pkg::*;
#(
    parameter int PHT_DEPTH = 8,
    parameter int GHR_LEN   = 8,
    parameter int CTR_W     = 2,
    parameter int CNT_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    branch_predict_gshare_spec_if.slave   bus
);

    localparam int N_ENT = 1 << PHT_DEPTH;
    localparam int SW    = PHT_DEPTH + 1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
    localparam logic [CTR_W-1:0] CTR_MAX  = CTR_W'(ctr_max(CTR_W));

    logic [CTR_W-1:0]     pht_q [N_ENT];
    logic [GHR_LEN-1:0]   ghr_spec_q, ghr_spec_d;
    // The oldest architectural bit never reaches recovery, so it is not kept.
    logic [GHR_LEN-2:0]   ghr_arch_q, ghr_arch_d;
    logic [CNT_W-1:0]     branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]     mispred_cnt_q, mispred_cnt_d;
    logic [CTR_W-1:0]     ctr_upd_d;

    logic [PHT_DEPTH-1:0] ghr_ext_s, idx_f_s, idx_m_s;
    logic [SW-1:0]        stage_f_s, stage_d_s, stage_e_s, stage_m_s;
    logic                 pred_f_s, pred_d_s, pred_m_s;
    logic                 mispredict_s, advance_s;
    logic [CTR_W-1:0]     ctr_cur_s;

    assign ghr_ext_s = PHT_DEPTH'(ghr_spec_q);
    assign idx_f_s   = bus.pcF[PHT_DEPTH+1:2] ^ ghr_ext_s;
    assign pred_f_s  = pht_q[idx_f_s][CTR_W-1];
    assign stage_f_s = {pred_f_s, idx_f_s};

    bp_stage_reg #(.W(SW)) u_stage_d (
        .clk(clk), .rst_n(rst), .clr_i(bus.flushD), .en_i(~bus.stallD),
        .d_i(stage_f_s), .q_o(stage_d_s)
    );
    bp_stage_reg #(.W(SW)) u_stage_e (
        .clk(clk), .rst_n(rst), .clr_i(bus.flushE), .en_i(1'b1),
        .d_i(stage_d_s), .q_o(stage_e_s)
    );
    bp_stage_reg #(.W(SW)) u_stage_m (
        .clk(clk), .rst_n(rst), .clr_i(bus.flushM), .en_i(1'b1),
        .d_i(stage_e_s), .q_o(stage_m_s)
    );

    assign pred_d_s     = stage_d_s[SW-1];
    assign pred_m_s     = stage_m_s[SW-1];
    assign idx_m_s      = stage_m_s[PHT_DEPTH-1:0];
    assign ctr_cur_s    = pht_q[idx_m_s];
    assign mispredict_s = bus.branchM & (pred_m_s ^ bus.actual_takeM);
    assign advance_s    = bus.branchD & ~bus.stallD & ~bus.flushE;

    // Next history, counter and statistics values; recovery beats speculation.
    always_comb begin
        ghr_arch_d    = ghr_arch_q;
        ghr_spec_d    = ghr_spec_q;
        ctr_upd_d     = ctr_cur_s;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bus.branchM) begin
            ghr_arch_d = GHR_LEN'({ghr_arch_q, bus.actual_takeM});
        end else begin
            ghr_arch_d = ghr_arch_q;
        end
        if (mispredict_s) begin
            ghr_spec_d = {ghr_arch_q, bus.actual_takeM};
        end else if (advance_s) begin
            ghr_spec_d = {ghr_spec_q[GHR_LEN-2:0], pred_d_s};
        end else begin
            ghr_spec_d = ghr_spec_q;
        end
        if (bus.actual_takeM) begin
            ctr_upd_d = (ctr_cur_s == CTR_MAX) ? ctr_cur_s : ctr_cur_s + CTR_W'(1);
        end else begin
            ctr_upd_d = (ctr_cur_s == {CTR_W{1'b0}}) ? ctr_cur_s : ctr_cur_s - CTR_W'(1);
        end
        if (bus.branchM && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end else begin
            branch_cnt_d = branch_cnt_q;
        end
        if (mispredict_s && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end else begin
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // Predictor state: PHT entry at the carried M index, histories, counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ENT; i++) begin
                pht_q[i] <= CTR_INIT;
            end
            ghr_spec_q    <= {GHR_LEN{1'b0}};
            ghr_arch_q    <= {(GHR_LEN-1){1'b0}};
            branch_cnt_q  <= {CNT_W{1'b0}};
            mispred_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (bus.branchM) begin
                pht_q[idx_m_s] <= ctr_upd_d;
            end
            ghr_spec_q    <= ghr_spec_d;
            ghr_arch_q    <= ghr_arch_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.pred_takeD  = bus.branchD & pred_d_s;
    assign bus.mispredictM = mispredict_s;
    assign bus.PHT_index   = idx_f_s;
    assign bus.ghr_spec    = ghr_spec_q;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_gshare_spec.sv
// Directed scoreboard bench for the gshare predictor (8/8/2 geometry), with a
// second instance at CNT_W=4 sharing the stimulus to exercise counter saturation.
module tb_branch_predict_gshare_spec;

    localparam int S_PRED  = 0;
    localparam int S_MISP  = 1;
    localparam int S_IDX   = 2;
    localparam int S_GHR   = 3;
    localparam int S_BCNT  = 4;
    localparam int S_MCNT  = 5;
    localparam int S_BCNT4 = 6;
    localparam int S_MCNT4 = 7;

    typedef struct {
        string       tag;
        int          sig;
        logic [63:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    branch_predict_gshare_spec_if #(.PHT_DEPTH(8), .GHR_LEN(8), .CNT_W(32)) bus ();
    branch_predict_gshare_spec_if #(.PHT_DEPTH(8), .GHR_LEN(8), .CNT_W(4))  bus4 ();

    branch_predict_gshare_spec #(.PHT_DEPTH(8), .GHR_LEN(8), .CTR_W(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    branch_predict_gshare_spec #(.PHT_DEPTH(8), .GHR_LEN(8), .CTR_W(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    assign bus4.pcF          = bus.pcF;
    assign bus4.stallD       = bus.stallD;
    assign bus4.flushD       = bus.flushD;
    assign bus4.flushE       = bus.flushE;
    assign bus4.flushM       = bus.flushM;
    assign bus4.branchD      = bus.branchD;
    assign bus4.branchM      = bus.branchM;
    assign bus4.actual_takeM = bus.actual_takeM;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] observe(input int sig);
        case (sig)
            S_PRED:  observe = 64'(bus.pred_takeD);
            S_MISP:  observe = 64'(bus.mispredictM);
            S_IDX:   observe = 64'(bus.PHT_index);
            S_GHR:   observe = 64'(bus.ghr_spec);
            S_BCNT:  observe = 64'(bus.branch_cnt);
            S_MCNT:  observe = 64'(bus.mispred_cnt);
            S_BCNT4: observe = 64'(bus4.branch_cnt);
            S_MCNT4: observe = 64'(bus4.mispred_cnt);
            default: observe = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int sig, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sig), e.exp);
        end
    endtask

    // Drive one cycle of inputs, check queued expectations mid-cycle, then advance.
    task automatic step(input logic [31:0] pc, input logic bd, input logic bm, input logic act,
                        input logic sd, input logic fd, input logic fe, input logic fm);
        bus.pcF          = pc;
        bus.branchD      = bd;
        bus.branchM      = bm;
        bus.actual_takeM = act;
        bus.stallD       = sd;
        bus.flushD       = fd;
        bus.flushE       = fe;
        bus.flushM       = fm;
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset with branch inputs active, so cleared stages are visible.
    task automatic do_reset(input logic [31:0] pc);
        logic [7:0] exp_idx;
        exp_idx          = pc[9:2];
        bus.pcF          = pc;
        bus.branchD      = 1'b1;
        bus.branchM      = 1'b1;
        bus.actual_takeM = 1'b0;
        bus.stallD       = 1'b0;
        bus.flushD       = 1'b0;
        bus.flushE       = 1'b0;
        bus.flushM       = 1'b0;
        rst              = 1'b0;
        #2;
        push("rst_pred", S_PRED, 64'h0);
        push("rst_misp", S_MISP, 64'h0);
        push("rst_idx",  S_IDX,  64'(exp_idx));
        push("rst_ghr",  S_GHR,  64'h0);
        push("rst_bcnt", S_BCNT, 64'h0);
        push("rst_mcnt", S_MCNT, 64'h0);
        push("rst_bcnt4", S_BCNT4, 64'h0);
        drain();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        #1;

        // Basic fetch, index hash and D flush.
        do_reset(32'h10);
        push("a_idx", S_IDX, 64'h04); push("a_bcnt", S_BCNT, 64'h0); push("a_mcnt", S_MCNT, 64'h0);
        step(32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("a_pred", S_PRED, 64'h1); push("a_idx2", S_IDX, 64'h04);
        step(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("a_ghr", S_GHR, 64'h01); push("a_idx_xor", S_IDX, 64'h05);
        step(32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push("a_flushd", S_PRED, 64'h0);
        step(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Not-taken training down to zero, no bypass, recovery over shift.
        do_reset(32'h40);
        push("b_idx", S_IDX, 64'h10);
        step(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("b_misp1", S_MISP, 64'h1);
        step(32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("b_misp2", S_MISP, 64'h1); push("b_nobypass", S_PRED, 64'h1);
        step(32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("b_recov_ghr", S_GHR, 64'h0); push("b_bcnt2", S_BCNT, 64'h2); push("b_mcnt2", S_MCNT, 64'h2);
        push("b_pred_ctr1", S_PRED, 64'h0); push("b_misp3", S_MISP, 64'h1);
        step(32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("b_pred_ctr0", S_PRED, 64'h0); push("b_bcnt3", S_BCNT, 64'h3); push("b_mcnt3", S_MCNT, 64'h3);
        push("b_ghr", S_GHR, 64'h0); push("b_misp_idle", S_MISP, 64'h0);
        step(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("b_sat0", S_PRED, 64'h0); push("b_ghr2", S_GHR, 64'h0);
        step(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // D stall holds the taken prediction while the fetch PC predicts not-taken.
        step(32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("s_hold1", S_PRED, 64'h1);
        step(32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push("s_hold2", S_PRED, 64'h1); push("s_ghr_st2", S_GHR, 64'h0);
        step(32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push("s_hold3", S_PRED, 64'h1); push("s_ghr_st3", S_GHR, 64'h0);
        step(32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push("s_release", S_PRED, 64'h1); push("s_ghr_rel", S_GHR, 64'h0);
        step(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("s_shift_once", S_GHR, 64'h1); push("s_new_d", S_PRED, 64'h0); push("s_idx", S_IDX, 64'h11);
        step(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("s_ghr_b", S_GHR, 64'h2);
        step(32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("s_hold_b", S_PRED, 64'h1);
        step(32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push("s_rel_fe", S_PRED, 64'h1); push("s_ghr_b2", S_GHR, 64'h2);
        step(32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push("s_fe_noshift", S_GHR, 64'h2); push("s_bcnt_pre", S_BCNT, 64'h3); push("s_mcnt_pre", S_MCNT, 64'h3);
        step(32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Mid-operation reset restores weakly-taken entries.
        do_reset(32'h40);
        step(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("r_pht_init", S_PRED, 64'h1);
        step(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Taken training saturates at the top, then recovery history re-targets the index.
        do_reset(32'h80);
        step(32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("c_misp_t1", S_MISP, 64'h0);
        step(32'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("c_misp_t2", S_MISP, 64'h0);
        step(32'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("c_misp_nt", S_MISP, 64'h1);
        step(32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("c_recov_ghr", S_GHR, 64'h06); push("c_idx", S_IDX, 64'h20);
        step(32'h98, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("c_sat_top", S_PRED, 64'h1);
        step(32'h98, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Two speculative taken shifts, then mispredict recovery to architectural history.
        do_reset(32'h40);
        step(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("d_pred1", S_PRED, 64'h1);
        step(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("d_pred2", S_PRED, 64'h1); push("d_ghr1", S_GHR, 64'h01);
        step(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("d_ghr3", S_GHR, 64'h03); push("d_idx", S_IDX, 64'h13); push("d_misp", S_MISP, 64'h1);
        step(32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push("d_ghr_rec", S_GHR, 64'h00); push("d_idx_rec", S_IDX, 64'h10); push("d_misp_idle", S_MISP, 64'h0);
        push("d_bcnt", S_BCNT, 64'h1); push("d_mcnt", S_MCNT, 64'h1);
        step(32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Statistics: M held flushed so predM=0 and a mispredict means actual taken.
        do_reset(32'h0);
        for (int i = 0; i < 20; i++) begin
            logic a;
            a = (i == 2) || (i == 5) || (i == 7);
            push("f_misp", S_MISP, 64'(a));
            if (i == 10) begin
                push("f_bcnt10", S_BCNT, 64'd10); push("f_mcnt3", S_MCNT, 64'd3);
                push("f_bcnt4_10", S_BCNT4, 64'd10);
            end
            step(32'h0, 1'b0, 1'b1, a, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        push("f_bcnt20", S_BCNT, 64'd20); push("f_mcnt_end", S_MCNT, 64'd3);
        push("f_bcnt4_sat", S_BCNT4, 64'd15); push("f_mcnt4", S_MCNT4, 64'd3);
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
